// File: rtl/exe_mem_reg_pkg.sv
// Shared types and defaults for the EXE->MEM pipeline register.
// Optional performance counters are enabled with the MEM_PERF_CNT_EN define.
package exe_mem_reg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;
    localparam int PERF_W     = 32;

    typedef struct packed {
        logic valid;
        logic wb_en;
        logic r_en;
        logic w_en;
    } ctrl_t;

    // A bubble clears every control bit; a load+store collision keeps only the store.
    function automatic ctrl_t capture_ctrl(input logic valid, input logic wb_en,
                                           input logic r_en, input logic w_en);
        ctrl_t c;
        c.valid = valid;
        c.wb_en = valid & wb_en;
        c.w_en  = valid & w_en;
        c.r_en  = valid & r_en & ~w_en;
        return c;
    endfunction

endpackage

// File: rtl/exe_mem_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; only built when MEM_PERF_CNT_EN is defined.
`ifdef MEM_PERF_CNT_EN
module exe_mem_reg_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register: holds a memory request until mem_ready and freezes upstream meanwhile.
// Define MEM_PERF_CNT_EN to add perf_mem_ops / perf_stall_cycles counters.
module exe_mem_reg
    import exe_mem_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic              exe_mem_w_en,
    input  logic [DATA_W-1:0] exe_alu_result,
    input  logic [DATA_W-1:0] exe_st_val,
    input  logic [REG_W-1:0]  exe_dest,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wb_en_out,
    output logic [REG_W-1:0]  dest_out,
    output logic              mem_valid_out,
    output logic              freeze
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_mem_ops,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic              busy;

    assign busy   = (state_q == BUSY);
    assign freeze = busy & ~mem_ready;

    // Capture whenever not frozen, so the ready cycle of one access also loads the next op.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        st_d    = st_q;
        dest_d  = dest_q;
        if (!freeze) begin
            ctrl_d  = capture_ctrl(exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en);
            addr_d  = exe_alu_result;
            st_d    = exe_st_val;
            dest_d  = exe_dest;
            state_d = (ctrl_d.r_en | ctrl_d.w_en) ? BUSY : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            addr_q  <= '0;
            st_q    <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            st_q    <= st_d;
            dest_q  <= dest_d;
        end
    end

    assign mem_read  = busy & ctrl_q.r_en;
    assign mem_write = busy & ctrl_q.w_en;
    assign address   = addr_q;
    assign data      = st_q;
    assign wb_en_out = ctrl_q.wb_en;
    assign dest_out  = dest_q;
    // A stalled access reports valid only on its completing cycle.
    assign mem_valid_out = busy ? mem_ready : ctrl_q.valid;

`ifdef MEM_PERF_CNT_EN
    exe_mem_reg_sat_counter #(.W(PERF_W)) u_ops_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (busy & mem_ready),
        .cnt_o (perf_mem_ops)
    );

    exe_mem_reg_sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (freeze),
        .cnt_o (perf_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg; counter checks are included when MEM_PERF_CNT_EN is defined.
module tb_exe_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en;
    logic [31:0] exe_alu_result, exe_st_val;
    logic [3:0]  exe_dest;
    logic        mem_ready;
    logic        mem_read, mem_write;
    logic [31:0] address, data;
    logic        wb_en_out;
    logic [3:0]  dest_out;
    logic        mem_valid_out, freeze;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_mem_ops, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    exe_mem_reg #(.DATA_W(32), .REG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .exe_valid      (exe_valid),
        .exe_wb_en      (exe_wb_en),
        .exe_mem_r_en   (exe_mem_r_en),
        .exe_mem_w_en   (exe_mem_w_en),
        .exe_alu_result (exe_alu_result),
        .exe_st_val     (exe_st_val),
        .exe_dest       (exe_dest),
        .mem_ready      (mem_ready),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .address        (address),
        .data           (data),
        .wb_en_out      (wb_en_out),
        .dest_out       (dest_out),
        .mem_valid_out  (mem_valid_out),
        .freeze         (freeze)
`ifdef MEM_PERF_CNT_EN
        ,
        .perf_mem_ops      (perf_mem_ops),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wb;
        logic [3:0]  dest;
        logic        mv;
        logic        frz;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] dat, input logic wb, input logic [3:0] dst,
                                input logic mv, input logic frz);
        exp_t e;
        e.rd = rd; e.wr = wr; e.addr = addr; e.data = dat;
        e.wb = wb; e.dest = dst; e.mv = mv; e.frz = frz;
        return e;
    endfunction

    // Drive one cycle of stimulus, queue what the DUT must show during it, compare at negedge.
    task automatic cyc(input string tag, input logic r, input logic v, input logic wb,
                       input logic ld, input logic st, input logic [31:0] alu,
                       input logic [31:0] sv, input logic [3:0] dst, input logic rdy,
                       input exp_t e);
        exp_t x;
        rst = r; exe_valid = v; exe_wb_en = wb; exe_mem_r_en = ld; exe_mem_w_en = st;
        exe_alu_result = alu; exe_st_val = sv; exe_dest = dst; mem_ready = rdy;
        if (v && ld && st)
            $display("[TB] error: illegal load+store issued in %s", tag);
        q.push_back(e);
        @(negedge clk);
        x = q.pop_front();
        chk({tag, ".req"},  {62'd0, mem_read, mem_write}, {62'd0, x.rd, x.wr});
        chk({tag, ".addr"}, {32'd0, address}, {32'd0, x.addr});
        chk({tag, ".data"}, {32'd0, data}, {32'd0, x.data});
        chk({tag, ".wb"},   {59'd0, wb_en_out, dest_out}, {59'd0, x.wb, x.dest});
        chk({tag, ".mv"},   {63'd0, mem_valid_out}, {63'd0, x.mv});
        chk({tag, ".frz"},  {63'd0, freeze}, {63'd0, x.frz});
        @(posedge clk);
        #1;
    endtask

    exp_t z;

    initial begin
        z = mk(0, 0, 32'h0, 32'h0, 0, 4'd0, 0, 0);
        rst = 1'b1; exe_valid = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_mem_w_en = 0;
        exe_alu_result = 0; exe_st_val = 0; exe_dest = 0; mem_ready = 0;
        @(posedge clk);
        #1;

        cyc("rst",   1, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, z);

        // ALU op, no memory access
        cyc("alu0",  0, 1, 1, 0, 0, 32'h10, 32'h0, 4'd3, 0, z);
        cyc("alu1",  0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(0, 0, 32'h10, 32'h0, 1, 4'd3, 1, 0));

        // Load with a 4-cycle miss; next EXE op waits
        cyc("ld0",   0, 1, 1, 1, 0, 32'h100, 32'h0, 4'd5, 0, z);
        cyc("ld1",   0, 1, 1, 0, 0, 32'h20, 32'h0, 4'd7, 0, mk(1, 0, 32'h100, 32'h0, 1, 4'd5, 0, 1));
        cyc("ld2",   0, 1, 1, 0, 0, 32'h20, 32'h0, 4'd7, 0, mk(1, 0, 32'h100, 32'h0, 1, 4'd5, 0, 1));
        cyc("ld3",   0, 1, 1, 0, 0, 32'h20, 32'h0, 4'd7, 0, mk(1, 0, 32'h100, 32'h0, 1, 4'd5, 0, 1));
        cyc("ld4",   0, 1, 1, 0, 0, 32'h20, 32'h0, 4'd7, 1, mk(1, 0, 32'h100, 32'h0, 1, 4'd5, 1, 0));
`ifdef MEM_PERF_CNT_EN
        chk("perf_ops_miss",   {32'd0, perf_mem_ops}, 64'd1);
        chk("perf_stall_miss", {32'd0, perf_stall_cycles}, 64'd3);
`endif
        cyc("ld5",   0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(0, 0, 32'h20, 32'h0, 1, 4'd7, 1, 0));

        // Store hit then load hit, back to back
        cyc("sl0",   0, 1, 0, 0, 1, 32'h200, 32'hCAFEBABE, 4'd0, 0, z);
        cyc("sl1",   0, 1, 1, 1, 0, 32'h300, 32'h0, 4'd2, 1, mk(0, 1, 32'h200, 32'hCAFEBABE, 0, 4'd0, 1, 0));
        cyc("sl2",   0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 1, mk(1, 0, 32'h300, 32'h0, 1, 4'd2, 1, 0));

        // Bubble with a stray mem_ready
        cyc("bub",   0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 1, z);
`ifdef MEM_PERF_CNT_EN
        chk("perf_ops_bub",   {32'd0, perf_mem_ops}, 64'd3);
        chk("perf_stall_bub", {32'd0, perf_stall_cycles}, 64'd3);
`endif

        // Reset on the second BUSY cycle of a load
        cyc("rm0",   0, 1, 1, 1, 0, 32'h400, 32'h0, 4'd9, 0, z);
        cyc("rm1",   0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(1, 0, 32'h400, 32'h0, 1, 4'd9, 0, 1));
        cyc("rm2",   1, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(1, 0, 32'h400, 32'h0, 1, 4'd9, 0, 1));
`ifdef MEM_PERF_CNT_EN
        chk("perf_ops_rst",   {32'd0, perf_mem_ops}, 64'd0);
        chk("perf_stall_rst", {32'd0, perf_stall_cycles}, 64'd0);
`endif
        cyc("rm3",   0, 1, 1, 0, 0, 32'h44, 32'h0, 4'd4, 0, z);
        cyc("rm4",   0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(0, 0, 32'h44, 32'h0, 1, 4'd4, 1, 0));

        // Load and store together: store wins
        cyc("ls0",   0, 1, 0, 1, 1, 32'h500, 32'h55, 4'd1, 1, z);
        cyc("ls1",   0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 1, mk(0, 1, 32'h500, 32'h55, 0, 4'd1, 1, 0));

`ifdef MEM_PERF_CNT_EN
        // Stall counter saturation
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.u_stall_cnt.cnt_q;
        @(posedge clk);
        #1;
        cyc("sat0",  0, 1, 1, 1, 0, 32'h600, 32'h0, 4'd6, 0, z);
        cyc("sat1",  0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(1, 0, 32'h600, 32'h0, 1, 4'd6, 0, 1));
        cyc("sat2",  0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(1, 0, 32'h600, 32'h0, 1, 4'd6, 0, 1));
        cyc("sat3",  0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, mk(1, 0, 32'h600, 32'h0, 1, 4'd6, 0, 1));
        cyc("sat4",  0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 1, mk(1, 0, 32'h600, 32'h0, 1, 4'd6, 1, 0));
        chk("perf_stall_sat", {32'd0, perf_stall_cycles}, 64'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
